// File: rtl/weight_bias_calc_pkg.sv
// rtl/weight_bias_calc_pkg.sv - Q8.24 fixed-point constants and multiply helper
package weight_bias_calc_pkg;

   localparam int WIDTH = 32;
   localparam int FRAC  = 24;
   localparam logic [WIDTH-1:0] ONE = 32'h0100_0000;

   // Full-width signed product, floor-shifted back to Q8.24 and wrapped to WIDTH bits
   function automatic logic [WIDTH-1:0] fmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] p;
      p = $signed(a) * $signed(b);
      return WIDTH'(p >>> FRAC);
   endfunction

endpackage

// File: rtl/weight_bias_calc_fxp_mul.sv
// rtl/weight_bias_calc_fxp_mul.sv - combinational signed Q8.24 multiply, truncated result
module fxp_mul
   import weight_bias_calc_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = fmul(a, b);

endmodule

// File: rtl/weight_bias_calc.sv
// rtl/weight_bias_calc.sv - backprop gradient accumulator for a single-hidden-layer MLP
module weight_bias_calc
   import weight_bias_calc_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int N_HL_P = 3,
   parameter int N_OUT  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [WIDTH-1:0]               i_lr,
   input  logic [N_IN*WIDTH-1:0]          i_k,
   input  logic [N_HL_P*WIDTH-1:0]        i_hd_a,
   input  logic [N_OUT*WIDTH-1:0]         i_dlto,
   input  logic [N_HL_P*WIDTH-1:0]        i_dlth,
   output logic [N_OUT*WIDTH-1:0]         o_bias_o,
   output logic [N_HL_P*WIDTH-1:0]        o_bias_hd,
   output logic [N_HL_P*N_OUT*WIDTH-1:0]  o_wght_o,
   output logic [N_HL_P*N_IN*WIDTH-1:0]   o_wght_hd
);

   logic [WIDTH-1:0] so   [N_OUT];
   logic [WIDTH-1:0] sh   [N_HL_P];
   logic [WIDTH-1:0] wo_t [N_OUT*N_HL_P];
   logic [WIDTH-1:0] wh_t [N_HL_P*N_IN];

   logic [N_OUT*WIDTH-1:0]        bias_o_q,  bias_o_d;
   logic [N_HL_P*WIDTH-1:0]       bias_hd_q, bias_hd_d;
   logic [N_HL_P*N_OUT*WIDTH-1:0] wght_o_q,  wght_o_d;
   logic [N_HL_P*N_IN*WIDTH-1:0]  wght_hd_q, wght_hd_d;

   // Learning-rate-scaled deltas feed both the bias terms and the second-stage weight multiplies
   for (genvar o = 0; o < N_OUT; o++) begin : g_out
      fxp_mul u_so (.a(i_lr), .b(i_dlto[o*WIDTH +: WIDTH]), .y(so[o]));
      for (genvar h = 0; h < N_HL_P; h++) begin : g_wo
         fxp_mul u_wo (.a(so[o]), .b(i_hd_a[h*WIDTH +: WIDTH]), .y(wo_t[o*N_HL_P+h]));
      end
   end

   for (genvar h = 0; h < N_HL_P; h++) begin : g_hid
      fxp_mul u_sh (.a(i_lr), .b(i_dlth[h*WIDTH +: WIDTH]), .y(sh[h]));
      for (genvar k = 0; k < N_IN; k++) begin : g_wh
         fxp_mul u_wh (.a(sh[h]), .b(i_k[k*WIDTH +: WIDTH]), .y(wh_t[h*N_IN+k]));
      end
   end

   always_comb begin
      bias_o_d  = bias_o_q;
      bias_hd_d = bias_hd_q;
      wght_o_d  = wght_o_q;
      wght_hd_d = wght_hd_q;
      if (en) begin
         for (int o = 0; o < N_OUT; o++)
            bias_o_d[o*WIDTH +: WIDTH] = bias_o_q[o*WIDTH +: WIDTH] + so[o];
         for (int h = 0; h < N_HL_P; h++)
            bias_hd_d[h*WIDTH +: WIDTH] = bias_hd_q[h*WIDTH +: WIDTH] + sh[h];
         for (int i = 0; i < N_OUT*N_HL_P; i++)
            wght_o_d[i*WIDTH +: WIDTH] = wght_o_q[i*WIDTH +: WIDTH] + wo_t[i];
         for (int i = 0; i < N_HL_P*N_IN; i++)
            wght_hd_d[i*WIDTH +: WIDTH] = wght_hd_q[i*WIDTH +: WIDTH] + wh_t[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bias_o_q  <= '0;
         bias_hd_q <= '0;
         wght_o_q  <= '0;
         wght_hd_q <= '0;
      end else begin
         bias_o_q  <= bias_o_d;
         bias_hd_q <= bias_hd_d;
         wght_o_q  <= wght_o_d;
         wght_hd_q <= wght_hd_d;
      end
   end

   assign o_bias_o  = bias_o_q;
   assign o_bias_hd = bias_hd_q;
   assign o_wght_o  = wght_o_q;
   assign o_wght_hd = wght_hd_q;

endmodule

// File: tb/tb_weight_bias_calc.sv
// tb/tb_weight_bias_calc.sv - directed self-checking bench for weight_bias_calc
module tb_weight_bias_calc;

   localparam int W      = 32;
   localparam int N_IN   = 2;
   localparam int N_HL_P = 3;
   localparam int N_OUT  = 2;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          en  = 1'b0;
   logic [W-1:0]                  i_lr = '0;
   logic [N_IN*W-1:0]             i_k = '0;
   logic [N_HL_P*W-1:0]           i_hd_a = '0;
   logic [N_OUT*W-1:0]            i_dlto = '0;
   logic [N_HL_P*W-1:0]           i_dlth = '0;
   logic [N_OUT*W-1:0]            o_bias_o;
   logic [N_HL_P*W-1:0]           o_bias_hd;
   logic [N_HL_P*N_OUT*W-1:0]     o_wght_o;
   logic [N_HL_P*N_IN*W-1:0]      o_wght_hd;

   weight_bias_calc #(.N_IN(N_IN), .N_HL_P(N_HL_P), .N_OUT(N_OUT)) dut (
      .clk(clk), .rst(rst), .en(en), .i_lr(i_lr), .i_k(i_k), .i_hd_a(i_hd_a),
      .i_dlto(i_dlto), .i_dlth(i_dlth), .o_bias_o(o_bias_o), .o_bias_hd(o_bias_hd),
      .o_wght_o(o_wght_o), .o_wght_hd(o_wght_hd)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] lr_v;
   logic [W-1:0] k_v  [N_IN];
   logic [W-1:0] a_v  [N_HL_P];
   logic [W-1:0] do_v [N_OUT];
   logic [W-1:0] dh_v [N_HL_P];

   logic [W-1:0] m_bo [N_OUT];
   logic [W-1:0] m_bh [N_HL_P];
   logic [W-1:0] m_wo [N_OUT*N_HL_P];
   logic [W-1:0] m_wh [N_HL_P*N_IN];

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference multiply: widen to 64 bits, floor-divide by 2^24, wrap
   function automatic logic [W-1:0] ref_fmul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      logic [63:0] u;
      p = longint'($signed(a)) * longint'($signed(b));
      p = p >>> 24;
      u = p;
      return u[W-1:0];
   endfunction

   task automatic clear_all();
      lr_v = '0;
      for (int i = 0; i < N_IN; i++) k_v[i] = '0;
      for (int i = 0; i < N_HL_P; i++) begin a_v[i] = '0; dh_v[i] = '0; end
      for (int i = 0; i < N_OUT; i++) do_v[i] = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_OUT; i++) m_bo[i] = '0;
      for (int i = 0; i < N_HL_P; i++) m_bh[i] = '0;
      for (int i = 0; i < N_OUT*N_HL_P; i++) m_wo[i] = '0;
      for (int i = 0; i < N_HL_P*N_IN; i++) m_wh[i] = '0;
   endtask

   task automatic model_add();
      logic [W-1:0] s;
      for (int o = 0; o < N_OUT; o++) begin
         s = ref_fmul(lr_v, do_v[o]);
         m_bo[o] += s;
         for (int h = 0; h < N_HL_P; h++) m_wo[o*N_HL_P+h] += ref_fmul(s, a_v[h]);
      end
      for (int h = 0; h < N_HL_P; h++) begin
         s = ref_fmul(lr_v, dh_v[h]);
         m_bh[h] += s;
         for (int k = 0; k < N_IN; k++) m_wh[h*N_IN+k] += ref_fmul(s, k_v[k]);
      end
   endtask

   task automatic drive();
      i_lr = lr_v;
      for (int i = 0; i < N_IN; i++) i_k[i*W +: W] = k_v[i];
      for (int i = 0; i < N_HL_P; i++) begin
         i_hd_a[i*W +: W] = a_v[i];
         i_dlth[i*W +: W] = dh_v[i];
      end
      for (int i = 0; i < N_OUT; i++) i_dlto[i*W +: W] = do_v[i];
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N_OUT; i++) check_val($sformatf("%s bias_o[%0d]", tag, i), o_bias_o[i*W +: W], m_bo[i]);
      for (int i = 0; i < N_HL_P; i++) check_val($sformatf("%s bias_hd[%0d]", tag, i), o_bias_hd[i*W +: W], m_bh[i]);
      for (int i = 0; i < N_OUT*N_HL_P; i++) check_val($sformatf("%s wght_o[%0d]", tag, i), o_wght_o[i*W +: W], m_wo[i]);
      for (int i = 0; i < N_HL_P*N_IN; i++) check_val($sformatf("%s wght_hd[%0d]", tag, i), o_wght_hd[i*W +: W], m_wh[i]);
   endtask

   // Drive on negedge, one en pulse of n cycles, sample on the following negedge
   task automatic pulse(input int n);
      @(negedge clk);
      drive();
      en = 1'b1;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         model_add();
      end
      en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic scramble();
      i_lr   = $urandom;
      i_k    = {$urandom, $urandom};
      i_hd_a = {$urandom, $urandom, $urandom};
      i_dlto = {$urandom, $urandom};
      i_dlth = {$urandom, $urandom, $urandom};
   endtask

   initial begin
      clear_all();
      model_reset();

      // Reset held with random inputs and en high
      scramble();
      en = 1'b1;
      repeat (3) @(negedge clk);
      check_all("rst_hold");
      en = 1'b0;
      rst = 1'b0;

      // Single output-path sample
      clear_all();
      lr_v = 32'h0019_999a;
      do_v[0] = 32'h0024_8272;
      a_v[0] = 32'h00f3_7fff;
      pulse(1);
      check_val("single bias_o0 const", o_bias_o[0 +: W], 32'h0003_A6A5);
      check_val("single wght_o0 const", o_wght_o[0 +: W], 32'h0003_7901);
      check_all("single");

      // Asynchronous reset mid-cycle, away from any rising edge
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Hidden path with inputs of 8.0
      clear_all();
      lr_v = 32'h0019_999a;
      k_v[0] = 32'h0800_0000;
      k_v[1] = 32'h0800_0000;
      dh_v[0] = 32'h0001_00fe;
      pulse(1);
      check_val("hidden bias_hd0 const", o_bias_hd[0 +: W], 32'h0000_19B3);
      check_val("hidden wght_hd0 const", o_wght_hd[0 +: W], 32'h0000_CD98);
      check_val("hidden wght_hd1 const", o_wght_hd[W +: W], 32'h0000_CD98);
      check_all("hidden");

      // Negative delta floors toward -inf
      do_reset();
      clear_all();
      lr_v = 32'h0019_999a;
      do_v[1] = 32'hffec_4a56;
      a_v[1] = 32'h0080_0000;
      pulse(1);
      check_val("neg bias_o1 const", o_bias_o[W +: W], 32'hFFFE_076E);
      check_all("neg");

      // Batch of four samples, inputs changing while en is low
      do_reset();
      for (int s = 0; s < 4; s++) begin
         lr_v    = 32'h0019_999a;
         k_v[0]  = (s < 2) ? 32'h0800_0000 : 32'h0500_0000;
         k_v[1]  = (s % 2 == 0) ? 32'h0800_0000 : 32'h0500_0000;
         a_v[0]  = 32'h00f3_7fff - 32'(s) * 32'h0011_0000;
         a_v[1]  = 32'h0040_0000 + 32'(s) * 32'h0003_1234;
         a_v[2]  = 32'h00c0_0000 ^ (32'(s) << 12);
         do_v[0] = 32'h0024_8272 + 32'(s) * 32'h0000_7777;
         do_v[1] = 32'hffec_4a56 - 32'(s) * 32'h0001_0101;
         dh_v[0] = 32'h0001_00fe + 32'(s) * 32'h0000_0a0b;
         dh_v[1] = 32'hfffe_1234 - 32'(s) * 32'h0000_3210;
         dh_v[2] = 32'h0003_0303 ^ (32'(s) << 8);
         pulse(1);
         scramble();
         repeat (2) @(negedge clk);
         check_all($sformatf("batch%0d", s));
      end

      // en held for two cycles accumulates twice
      pulse(2);
      check_all("en_x2");

      // Long idle with toggling inputs
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         scramble();
      end
      check_all("idle");

      // Reset and en high together: reset wins
      @(negedge clk);
      rst = 1'b1;
      en = 1'b1;
      @(negedge clk);
      model_reset();
      check_all("rst_en");
      en = 1'b0;
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/weight_bias_calc.md
Name: weight_bias_calc

Overview:
Backpropagation gradient accumulator for a single-hidden-layer MLP.
- Each sample is qualified by `en`.
- For each weight and bias, it forms the learning-rate-scaled update term lr·δ·activation.
- It accumulates these terms into registered sums for the output-layer and hidden-layer weights and biases.
- It sits between the delta-calculation stage and the weight-update stage.

Parameters:
- N_IN, 2, number of network inputs.
- N_HL_P, 3, number of hidden-layer perceptrons.
- N_OUT, 2, number of output perceptrons.
- WIDTH, 32, word width; signed fixed point Q8.24 (FRAC = 24, 1.0 = 0x01000000).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  sample-valid; accumulate one sample per cycle while high.
- i_lr  in  WIDTH  learning rate, Q8.24 signed.
- i_k  in  N_IN*WIDTH  network inputs; slice k = bits [k*WIDTH +: WIDTH].
- i_hd_a  in  N_HL_P*WIDTH  hidden activations; slice h.
- i_dlto  in  N_OUT*WIDTH  output-layer deltas; slice o.
- i_dlth  in  N_HL_P*WIDTH  hidden-layer deltas; slice h.
- o_bias_o  out  N_OUT*WIDTH  accumulated output bias updates; slice o.
- o_bias_hd  out  N_HL_P*WIDTH  accumulated hidden bias updates; slice h.
- o_wght_o  out  N_HL_P*N_OUT*WIDTH  accumulated output-weight updates; slice index o*N_HL_P+h.
- o_wght_hd  out  N_HL_P*N_IN*WIDTH  accumulated hidden-weight updates; slice index h*N_IN+k.

Behaviour:
- Reset (async, rst=1): all output registers are cleared to 0 immediately and held while rst=1.
- fmul(a,b): full 2*WIDTH signed product, arithmetic shift right by FRAC, keep low WIDTH bits. Truncation is toward −inf; no rounding, no saturation; overflow wraps.
- Per sample:
  - so[o] = fmul(i_lr, i_dlto[o]); sh[h] = fmul(i_lr, i_dlth[h]).
  - Bias terms are so[o] and sh[h].
  - Output-weight term = fmul(so[o], i_hd_a[h]).
  - Hidden-weight term = fmul(sh[h], i_k[k]).
- Rising clk with en=1: every output register += its term (WIDTH-bit two's-complement add, wraps).
- With en=0: all registers hold.
- Latency: the output reflects the sample on the clock edge where en=1; visible the same cycle after that edge.
- Datapath is combinational from inputs to adders; one register stage only.
- Inputs are sampled only on en edges; changes while en=0 have no effect.
- en held high for n cycles accumulates the same sample n times. This is intended; upstream guarantees a 1-cycle pulse per sample.
- rst asserted mid-batch discards all accumulated values.
- rst and en high together: rst wins.

Decomposition:
- Shared package holds:
  - fixed-point constants WIDTH=32, FRAC=24, ONE=0x01000000;
  - the fmul function, or equivalent.
- One natural sub-module, fxp_mul: a combinational signed Q8.24 multiply with a WIDTH-bit truncated result. It is instantiated per term via generate loops over o, h, k.

Test Plan:
1. Reset: rst=1 with random inputs, clk running -> all outputs 0; assert rst asynchronously mid-cycle -> outputs clear without a clock edge.
2. Single sample, lr=0x0019999a (0.1), i_dlto[0]=0x00248272, i_hd_a[0]=0x00f37fff, one en pulse:
   - o_bias_o[0] = 0x0003A6A5;
   - o_wght_o[0] = fmul(0x0003A6A5, 0x00f37fff) = 0x00037901.
3. Hidden path: i_k = 8.0 (0x08000000) both, i_dlth[0]=0x000100fe, one en pulse:
   - o_bias_hd[0] = fmul(lr, 0x000100fe);
   - o_wght_hd[0] and o_wght_hd[1] = 8 × that value, within truncation.
4. Negative delta: i_dlto[1]=0xffec4a56 -> o_bias_o[1] negative; it equals the floor-truncated fmul result, checked bit-exact against the reference model.
5. Batch of 4 samples, (8,8), (8,5), (5,8), (5,5), with the distinct activations and deltas; one en pulse each, inputs changing while en=0 -> every output equals the sum of 4 model terms; no change between pulses.
6. en held 2 cycles -> terms added twice; en=0 for long periods with toggling inputs -> outputs constant.
